// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide engine for the EX stage
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   funct        EX-stage funct (MULT 0x18, MULTU 0x19, DIV 0x1a, DIVU 0x1b)
//   operand_1    rs value (multiplicand / dividend)
//   operand_2    rt value (multiplier / divisor)
//   flush        aborts the current operation, result left untouched
//   ex_stall_in  keeps a finished result presented while EX is held downstream
//   done         result valid (registered, decoded from state)
//   result       {HI,LO}: 64-bit product or {remainder, quotient}

module mult_div_unit #(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        flush,
    input  logic        ex_stall_in,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  counter;
    logic        op_div;
    logic        neg_lo;      // negate product (mult) or quotient (div)
    logic        neg_hi;      // negate remainder (div only)
    logic [31:0] addend;      // multiplicand magnitude or divisor magnitude
    logic [31:0] hi_reg;      // product high half / partial remainder
    logic [31:0] lo_reg;      // multiplier bits / dividend bits shifting into quotient

    // Request decode
    logic        is_req;
    logic        req_div;
    logic        req_signed;
    logic        sign_1;
    logic        sign_2;
    logic [31:0] mag_1;
    logic [31:0] mag_2;
    logic        op1_zero;
    logic        op2_zero;
    logic        zero_case;
    logic [63:0] zero_result;

    assign is_req     = (funct == 6'h18) || (funct == 6'h19) ||
                        (funct == 6'h1a) || (funct == 6'h1b);
    assign req_div    = funct[1];
    assign req_signed = ~funct[0];
    assign sign_1     = req_signed & operand_1[31];
    assign sign_2     = req_signed & operand_2[31];
    assign mag_1      = sign_1 ? (~operand_1 + 32'd1) : operand_1;
    assign mag_2      = sign_2 ? (~operand_2 + 32'd1) : operand_2;
    assign op1_zero   = (operand_1 == 32'd0);
    assign op2_zero   = (operand_2 == 32'd0);
    assign zero_case  = ZERO_SKIP && (req_div ? op2_zero : (op1_zero || op2_zero));
    assign zero_result = req_div ? {operand_1, 32'hFFFF_FFFF} : 64'd0;

    // One shift-add multiply step
    logic [32:0] mul_sum;
    logic [31:0] mul_hi_next;
    logic [31:0] mul_lo_next;

    assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, addend} : 33'd0);
    assign mul_hi_next = mul_sum[32:1];
    assign mul_lo_next = {mul_sum[0], lo_reg[31:1]};

    // One restoring divide step. The remainder always fits in 32 bits: it stays
    // below the divisor, or with a zero divisor it just collects dividend bits.
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_hi_next;
    logic [31:0] div_lo_next;

    assign div_shift   = {hi_reg, lo_reg[31]};
    assign div_trial   = div_shift - {1'b0, addend};
    assign div_ge      = ~div_trial[32];
    assign div_hi_next = div_ge ? div_trial[31:0] : div_shift[31:0];
    assign div_lo_next = {lo_reg[30:0], div_ge};

    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic [63:0] prod;
    logic [63:0] final_result;

    assign hi_next = op_div ? div_hi_next : mul_hi_next;
    assign lo_next = op_div ? div_lo_next : mul_lo_next;
    assign prod    = {hi_next, lo_next};

    always_comb begin
        final_result = prod;
        if (op_div) begin
            final_result[63:32] = neg_hi ? (~hi_next + 32'd1) : hi_next;
            final_result[31:0]  = neg_lo ? (~lo_next + 32'd1) : lo_next;
        end else if (neg_lo) begin
            final_result = ~prod + 64'd1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_req) begin
                        state_next = zero_case ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (counter == 5'd31) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (!ex_stall_in) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign done = (state == DONE);

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= 5'd0;
            op_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            addend  <= 32'd0;
            hi_reg  <= 32'd0;
            lo_reg  <= 32'd0;
            result  <= 64'd0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (is_req) begin
                        counter <= 5'd0;
                        op_div  <= req_div;
                        hi_reg  <= 32'd0;
                        if (req_div) begin
                            // A zero divisor runs on the raw dividend with no fixup,
                            // so the algorithm yields q=all ones, r=operand_1.
                            addend <= mag_2;
                            lo_reg <= op2_zero ? operand_1 : mag_1;
                            neg_lo <= (sign_1 ^ sign_2) & ~op2_zero;
                            neg_hi <= sign_1 & ~op2_zero;
                        end else begin
                            addend <= mag_1;
                            lo_reg <= mag_2;
                            neg_lo <= sign_1 ^ sign_2;
                            neg_hi <= 1'b0;
                        end
                        if (zero_case) begin
                            result <= zero_result;
                        end
                    end
                end
                CALC: begin
                    hi_reg  <= hi_next;
                    lo_reg  <= lo_next;
                    counter <= counter + 5'd1;
                    if (counter == 5'd31) begin
                        result <= final_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide engine and sequencer that serves the EX stage for MULT, MULTU, DIV and DIVU.
- Watches EX-stage funct/operands, latches operands on start, runs a radix-2 shift-add multiply or restoring divide over 32 cycles, and presents a 64-bit {HI,LO} result with a done flag.
- EX holds the pipeline (stall request = !done) until done is seen, then writes HI/LO.

Parameters:
- ZERO_SKIP, 1, when 1 a zero divisor (DIV/DIVU) or any zero operand (MULT/MULTU) bypasses CALC and goes straight to DONE.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- funct  input  6  EX-stage funct; MULT=6'h18, MULTU=6'h19, DIV=6'h1a, DIVU=6'h1b; all other codes are not requests
- operand_1  input  32  rs value (multiplicand / dividend)
- operand_2  input  32  rt value (multiplier / divisor)
- flush  input  1  pipeline flush (exception/eret); aborts the current operation
- ex_stall_in  input  1  downstream stall holding EX; keeps a finished result presented
- done  output  1  result valid; EX may retire the instruction
- result  output  64  {HI,LO}: product[63:0], or {remainder, quotient}

Behaviour:
- Reset: state=IDLE, done=0, result=64'h0, counter=0, internal registers cleared. Reset mid-operation discards the operation.
- States: IDLE, CALC, DONE. done=1 only in DONE; done is decoded from state (registered state, no combinational path from inputs).
- Precedence each edge: rst > flush > normal transitions. flush moves any state to IDLE; result is not modified.
- IDLE: if funct is one of the four codes, latch operands as magnitudes (|x| for signed ops, raw for unsigned), latch op type and sign flags, clear counter, go to CALC. With ZERO_SKIP=1 and a zero case, write the zero-case result and go to DONE.
- CALC: one iteration per cycle, counter 0..31. Operands latched at start; funct/operand changes during CALC are ignored. At counter==31, apply sign fixup, write result, go to DONE.
- Latency: request sampled in IDLE at cycle 0; done=1 in cycle 33 (cycle 1 with zero skip).
- DONE: result held stable. If ex_stall_in=1, stay in DONE with done=1. Otherwise go to IDLE.
- No re-execution: the instruction that just completed has left EX when IDLE is re-entered. Back-to-back requests restart from the IDLE sample, giving a 1-cycle IDLE gap.
- Multiply: 64-bit unsigned product of magnitudes. MULT negates the full 64 bits if sign(op1)^sign(op2).
- Divide: restoring, 32 quotient bits MSB-first, 33-bit partial remainder.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- Divide by zero (any ZERO_SKIP):
  - quotient = 32'hFFFFFFFF, remainder = operand_1 (raw).
  - Through CALC this must fall out of the restoring algorithm with no sign fixup applied to the zero-divisor case.
- Multiply with a zero operand: result=0.
- result persists after DONE until the next completion or reset. No result is written on flush.

Test Plan:
- MULT op1=0xFFFFFFFD (-3), op2=7 -> done at cycle 33, result=64'hFFFFFFFF_FFFFFFEB; MULTU same operands -> 64'h00000006_FFFFFFEB.
- DIVU 100/7 -> result={32'd2, 32'd14}; DIV -7/2 -> {32'hFFFFFFFF, 32'hFFFFFFFD}; DIV 0x80000000/-1 -> {0, 32'h80000000}.
- DIV 5/0, ZERO_SKIP=1 -> done in cycle 1, result={32'd5, 32'hFFFFFFFF}. With ZERO_SKIP=0 -> same value at cycle 33.
- MULT start, flush at counter 10 -> IDLE next cycle, done never asserts, result keeps its prior value. New DIVU next cycle completes correctly.
- Completion with ex_stall_in=1 for 3 cycles -> done stays 1 for 4 cycles with result stable and no restart. Drop stall -> IDLE.
- Two back-to-back MULTU, then rst asserted mid-CALC of the second -> done=0 and result=0 immediately (asynchronously). Restart after deassert behaves normally.
